// File: rtl/linear_pkg.sv
// Shared definitions for the linear layer sequencer: sequencer states,
// default layer geometry and memory address widths.
package linear_pkg;

    localparam int unsigned IN_LEN_DEF = 288;
    localparam int unsigned OUT_CH_DEF = 10;

    localparam int unsigned FEAT_AW = 9;
    localparam int unsigned W_AW    = 13;
    localparam int unsigned B_AW    = 4;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        FLUSH,
        CAPT,
        OUT
    } state_e;

endpackage

// File: rtl/linear_seq_addr_gen.sv
// Input-iteration and output-channel counters for the linear sequencer.
// The weight address walks o*IN_LEN+i with a plain incrementer.
module linear_seq_addr_gen
    import linear_pkg::*;
#(
    parameter int unsigned IN_LEN = IN_LEN_DEF,
    parameter int unsigned OUT_CH = OUT_CH_DEF
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               clear_i,
    input  logic               step_i,
    input  logic               next_ch_i,
    output logic [FEAT_AW-1:0] iter_o,
    output logic [B_AW-1:0]    ch_o,
    output logic [W_AW-1:0]    w_addr_o,
    output logic               last_iter_o,
    output logic               last_ch_o
);

    localparam logic [FEAT_AW-1:0] LAST_ITER = FEAT_AW'(IN_LEN - 1);
    localparam logic [B_AW-1:0]    LAST_CH   = B_AW'(OUT_CH - 1);

    logic [FEAT_AW-1:0] iter_q, iter_d;
    logic [B_AW-1:0]    ch_q, ch_d;
    logic [W_AW-1:0]    w_addr_q, w_addr_d;

    // Channel rows are contiguous, so advancing to the next channel is
    // just one more increment of the weight address after its last iteration.
    always_comb begin
        iter_d   = iter_q;
        ch_d     = ch_q;
        w_addr_d = w_addr_q;
        if (clear_i) begin
            iter_d   = '0;
            ch_d     = '0;
            w_addr_d = '0;
        end else if (next_ch_i) begin
            iter_d   = '0;
            ch_d     = ch_q + 1'b1;
            w_addr_d = w_addr_q + 1'b1;
        end else if (step_i) begin
            iter_d   = iter_q + 1'b1;
            w_addr_d = w_addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            iter_q   <= '0;
            ch_q     <= '0;
            w_addr_q <= '0;
        end else begin
            iter_q   <= iter_d;
            ch_q     <= ch_d;
            w_addr_q <= w_addr_d;
        end
    end

    assign iter_o      = iter_q;
    assign ch_o        = ch_q;
    assign w_addr_o    = w_addr_q;
    assign last_iter_o = (iter_q == LAST_ITER);
    assign last_ch_o   = (ch_q == LAST_CH);

endmodule

// File: rtl/linear_seq.sv
// Sequencer for a fully connected layer: streams feature/weight/bias reads
// into an external MAC and hands each channel's result out on a ready/valid port.
module linear_seq
    import linear_pkg::*;
#(
    parameter int unsigned IN_LEN = IN_LEN_DEF,
    parameter int unsigned OUT_CH = OUT_CH_DEF
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                start_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [FEAT_AW-1:0]  feat_addr_o,
    input  logic signed [7:0]   feat_rdata_i,
    output logic [W_AW-1:0]     w_addr_o,
    input  logic signed [7:0]   w_rdata_i,
    output logic [B_AW-1:0]     b_addr_o,
    input  logic signed [31:0]  b_rdata_i,
    output logic                mac_en_o,
    output logic [FEAT_AW-1:0]  mac_iter_o,
    output logic [7:0]          mac_data_o,
    output logic [7:0]          mac_weight_o,
    output logic [31:0]         mac_bias_o,
    input  logic signed [31:0]  mac_acc_i,
    output logic                res_valid_o,
    input  logic                res_ready_i,
    output logic [B_AW-1:0]     res_ch_o,
    output logic signed [31:0]  res_data_o
);

    state_e state_q, state_d;

    logic clear, step, next_ch, capture, handshake, finish;
    logic last_iter, last_ch;
    logic [FEAT_AW-1:0] iter;
    logic [B_AW-1:0]    ch;

    logic               mac_en_q;
    logic [FEAT_AW-1:0] mac_iter_q;
    logic               res_valid_q;
    logic [B_AW-1:0]    res_ch_q;
    logic signed [31:0] res_data_q;
    logic               done_q;

    linear_seq_addr_gen #(
        .IN_LEN (IN_LEN),
        .OUT_CH (OUT_CH)
    ) u_addr_gen (
        .clk         (clk),
        .rst_b       (rst_b),
        .clear_i     (clear),
        .step_i      (step),
        .next_ch_i   (next_ch),
        .iter_o      (iter),
        .ch_o        (ch),
        .w_addr_o    (w_addr_o),
        .last_iter_o (last_iter),
        .last_ch_o   (last_ch)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FLUSH gives the MAC one cycle to fold in the last product before CAPT.
    always_comb begin
        state_d   = state_q;
        clear     = 1'b0;
        step      = 1'b0;
        next_ch   = 1'b0;
        capture   = 1'b0;
        handshake = 1'b0;
        finish    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    clear   = 1'b1;
                end
            end
            RUN: begin
                if (last_iter) state_d = FLUSH;
                else           step    = 1'b1;
            end
            FLUSH: state_d = CAPT;
            CAPT: begin
                capture = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                if (res_ready_i) begin
                    handshake = 1'b1;
                    if (last_ch) begin
                        state_d = IDLE;
                        finish  = 1'b1;
                    end else begin
                        state_d = RUN;
                        next_ch = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The MAC strobe lags address issue by one cycle to line up with read data.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            mac_en_q    <= 1'b0;
            mac_iter_q  <= '0;
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            mac_en_q   <= (state_q == RUN);
            mac_iter_q <= iter;
            done_q     <= finish;
            if (capture) begin
                res_valid_q <= 1'b1;
                res_ch_q    <= ch;
                res_data_q  <= mac_acc_i;
            end else if (handshake) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign busy_o       = (state_q != IDLE);
    assign done_o       = done_q;
    assign feat_addr_o  = iter;
    assign b_addr_o     = ch;
    assign mac_en_o     = mac_en_q;
    assign mac_iter_o   = mac_iter_q;
    assign mac_data_o   = feat_rdata_i;
    assign mac_weight_o = w_rdata_i;
    assign mac_bias_o   = b_rdata_i;
    assign res_valid_o  = res_valid_q;
    assign res_ch_o     = res_ch_q;
    assign res_data_o   = res_data_q;

endmodule
